// File: rtl/ack_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ack_bus_pkg
// Description : Shared definitions for the ACK bus: the fixed source IDs,
//               the requester FSM state encoding and the gap counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package ack_bus_pkg;

  // Fixed ACK bus source IDs; lower value wins arbitration.
  localparam logic [1:0] ID_MEM  = 2'b00;
  localparam logic [1:0] ID_SHA  = 2'b01;
  localparam logic [1:0] ID_AES  = 2'b10;
  localparam logic [1:0] ID_CTRL = 2'b11;

  // Requester FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAP  = 2'd2
  } client_state_t;

  // Width of the post-grant back-off counter (GAP_CYCLES up to 15)
  localparam int GAP_W = 4;

endpackage
`default_nettype wire

// File: rtl/ack_client_pending_ctr.sv
`default_nettype none
// ============================================================================
// Module      : ack_client_pending_ctr
// Description : Saturating up/down counter of ACKs owed to the ACK bus.
//               An increment at full scale is dropped and latches the sticky
//               overflow flag; a simultaneous increment and decrement cancel.
// Ports       : clk, rst (async, active high)
//               inc      - add one queued ACK
//               dec      - retire one queued ACK
//               cnt      - current queued ACK count
//               overflow - sticky, an increment was dropped at full scale
// Revision    : 1.0 - initial release
// ============================================================================
module ack_client_pending_ctr #(
  parameter int PEND_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              dec,
  output logic [PEND_W-1:0] cnt,
  output logic              overflow
);

  localparam logic [PEND_W-1:0] c_max_cnt = '1;

  logic [PEND_W-1:0] r_cnt;
  logic              r_overflow;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_overflow <= 1'b0;
    end else begin
      case ({inc, dec})
        2'b10: begin
          if (r_cnt == c_max_cnt) r_overflow <= 1'b1;
          else                    r_cnt      <= r_cnt + 1'b1;
        end
        2'b01: begin
          // Never wraps below zero even if a stray decrement arrives
          if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign cnt      = r_cnt;
  assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: rtl/ack_bus_client.sv
`default_nettype none
// ============================================================================
// Module      : ack_bus_client
// Description : Per-source requester for the shared ACK bus. Queues the
//               source's completion events, requests the bus until granted,
//               retires one ACK per grant and then backs off GAP_CYCLES
//               cycles so lower-priority sources can win.
// Config      : define ACK_CLIENT_TIMEOUT_EN to enable starvation detection
//               (sticky 'starved' after TIMEOUT ungranted REQ cycles);
//               otherwise 'starved' is tied low.
// Ports       : clk, rst (async, active high)
//               done_pulse       - source finished a transaction owing an ACK
//               ack_ready        - arbiter grant line for this source
//               ack_event        - arbiter broadcast: a grant is issued
//               winner_source_id - arbiter broadcast winner ID
//               req              - request to the ACK bus
//               ack_sent         - one-cycle pulse, one pending ACK retired
//               pending_cnt      - queued ACKs not yet granted
//               overflow         - sticky, done_pulse dropped at full count
//               proto_err        - sticky, inconsistent grant observed
//               starved          - sticky, request timed out
// Revision    : 1.0 - initial release
// ============================================================================
module ack_bus_client
  import ack_bus_pkg::*;
#(
  parameter logic [1:0] SOURCE_ID  = 2'b00,
  parameter int         PEND_W     = 2,
  parameter int         GAP_CYCLES = 1,
  parameter int         TIMEOUT    = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              done_pulse,
  input  logic              ack_ready,
  input  logic              ack_event,
  input  logic [1:0]        winner_source_id,
  output logic              req,
  output logic              ack_sent,
  output logic [PEND_W-1:0] pending_cnt,
  output logic              overflow,
  output logic              proto_err,
  output logic              starved
);

  // Elaboration-time parameter sanity checks
  if ((GAP_CYCLES < 1) || (GAP_CYCLES > 15)) begin : g_chk_gap
    $error("ack_bus_client: GAP_CYCLES must be in 1..15");
  end
  if (TIMEOUT < 1) begin : g_chk_timeout
    $error("ack_bus_client: TIMEOUT must be at least 1");
  end

  localparam logic [GAP_W-1:0] c_gap_load = GAP_W'(GAP_CYCLES - 1);

  client_state_t     r_state;
  logic [GAP_W-1:0]  r_gap_cnt;
  logic              r_ack_sent;
  logic              r_proto_err;

  logic              w_req;
  logic              w_grant;
  logic              w_proto_bad;
  logic              w_pending_after;
  logic [PEND_W-1:0] w_pend_cnt;
  logic              w_overflow;

  assign w_req   = (r_state == ST_REQ);
  assign w_grant = w_req & ack_ready & ack_event & (winner_source_id == SOURCE_ID);

  // Any asserted grant line that does not form a clean grant is a protocol
  // fault; such a cycle never satisfies w_grant.
  assign w_proto_bad = ack_ready & (~w_req | ~ack_event | (winner_source_id != SOURCE_ID));

  // Count as it will be after this edge. No grant can occur outside REQ, so
  // in GAP only a new done_pulse can change it (and never to zero).
  assign w_pending_after = (w_pend_cnt != '0) | done_pulse;

  ack_client_pending_ctr #(
    .PEND_W (PEND_W)
  ) u_pending_ctr (
    .clk      (clk),
    .rst      (rst),
    .inc      (done_pulse),
    .dec      (w_grant),
    .cnt      (w_pend_cnt),
    .overflow (w_overflow)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_gap_cnt   <= '0;
      r_ack_sent  <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      r_ack_sent <= w_grant;
      if (w_proto_bad) r_proto_err <= 1'b1;

      case (r_state)
        ST_IDLE: begin
          if (w_pend_cnt != '0) r_state <= ST_REQ;
        end
        ST_REQ: begin
          if (w_grant) begin
            r_state   <= ST_GAP;
            r_gap_cnt <= c_gap_load;
          end
        end
        ST_GAP: begin
          if (r_gap_cnt == '0) r_state <= w_pending_after ? ST_REQ : ST_IDLE;
          else                 r_gap_cnt <= r_gap_cnt - 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef ACK_CLIENT_TIMEOUT_EN
  localparam int                  c_wait_w  = $clog2(TIMEOUT + 1);
  localparam logic [c_wait_w-1:0] c_timeout = c_wait_w'(TIMEOUT);

  logic [c_wait_w-1:0] r_wait_cnt;
  logic                r_starved;

  // Held at zero outside REQ so each REQ entry starts a fresh wait; saturates
  // at TIMEOUT while the request keeps waiting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait_cnt <= '0;
      r_starved  <= 1'b0;
    end else if (r_state != ST_REQ) begin
      r_wait_cnt <= '0;
    end else if (!w_grant && (r_wait_cnt != c_timeout)) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
      if (r_wait_cnt == c_timeout - 1'b1) r_starved <= 1'b1;
    end
  end

  assign starved = r_starved;
`else
  assign starved = 1'b0;
`endif

  assign req         = w_req;
  assign ack_sent    = r_ack_sent;
  assign pending_cnt = w_pend_cnt;
  assign overflow    = w_overflow;
  assign proto_err   = r_proto_err;

endmodule
`default_nettype wire

// File: tb/tb_ack_bus_client.sv
`default_nettype none
// ============================================================================
// Module      : tb_ack_bus_client
// Description : Self-checking bench for ack_bus_client (SOURCE_ID = SHA,
//               PEND_W = 2, GAP_CYCLES = 2, TIMEOUT = 8). Expected pending
//               counts at each ack_sent pulse are queued by the stimulus and
//               checked by an independent monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ack_bus_client;
  import ack_bus_pkg::*;

  localparam logic [1:0] SRC = ID_SHA;
`ifdef ACK_CLIENT_TIMEOUT_EN
  localparam int EXP_STARVED = 1;
`else
  localparam int EXP_STARVED = 0;
`endif

  // Arbiter model modes
  localparam int ARB_OFF  = 0;  // no grant activity
  localparam int ARB_AUTO = 1;  // grant this source whenever it requests
  localparam int ARB_BAD  = 2;  // grant lines up, wrong winner ID
  localparam int ARB_MEM  = 3;  // MEM wins every cycle

  logic       clk = 1'b0;
  logic       rst;
  logic       done_pulse;
  logic       ack_ready;
  logic       ack_event;
  logic [1:0] winner_source_id;
  logic       req;
  logic       ack_sent;
  logic [1:0] pending_cnt;
  logic       overflow;
  logic       proto_err;
  logic       starved;

  int         arb_mode = ARB_OFF;
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [1:0] exp_q[$];

  always #5 clk = ~clk;

  ack_bus_client #(
    .SOURCE_ID  (SRC),
    .PEND_W     (2),
    .GAP_CYCLES (2),
    .TIMEOUT    (8)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .done_pulse       (done_pulse),
    .ack_ready        (ack_ready),
    .ack_event        (ack_event),
    .winner_source_id (winner_source_id),
    .req              (req),
    .ack_sent         (ack_sent),
    .pending_cnt      (pending_cnt),
    .overflow         (overflow),
    .proto_err        (proto_err),
    .starved          (starved)
  );

  // Combinational arbiter model
  always_comb begin
    ack_ready        = 1'b0;
    ack_event        = 1'b0;
    winner_source_id = ID_MEM;
    case (arb_mode)
      ARB_AUTO: begin
        ack_ready        = req;
        ack_event        = req;
        winner_source_id = SRC;
      end
      ARB_BAD: begin
        ack_ready        = 1'b1;
        ack_event        = 1'b1;
        winner_source_id = ID_AES;
      end
      ARB_MEM: begin
        ack_event        = 1'b1;
        winner_source_id = ID_MEM;
      end
      default: ;
    endcase
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    arb_mode   = ARB_OFF;
    done_pulse = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Scoreboard monitor: every ack_sent pulse must match a queued expectation
  always @(negedge clk) begin
    if (ack_sent) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL ack_sent_unexpected: actual=pulse required=none (t=%0t)", $time);
      end else begin
        logic [1:0] e;
        e = exp_q.pop_front();
        if (pending_cnt !== e) begin
          n_fail++;
          $display("FAIL ack_sent_cnt: actual=%0d required=%0d (t=%0t)", pending_cnt, e, $time);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ack_times[$];

    // ---------------- reset state ----------------
    rst        = 1'b1;
    done_pulse = 1'b0;
    #12;
    check("rst_req",       int'(req), 0);
    check("rst_ack_sent",  int'(ack_sent), 0);
    check("rst_cnt",       int'(pending_cnt), 0);
    check("rst_overflow",  int'(overflow), 0);
    check("rst_proto_err", int'(proto_err), 0);
    check("rst_starved",   int'(starved), 0);
    do_reset();

    // ---------------- single ACK, immediate grant ----------------
    arb_mode   = ARB_AUTO;
    done_pulse = 1'b1;
    tick();                                   // E0
    done_pulse = 1'b0;
    check("t1_cnt_after_e0", int'(pending_cnt), 1);
    check("t1_req_after_e0", int'(req), 0);
    exp_q.push_back(2'd0);
    tick();                                   // E1
    check("t1_req_after_e1", int'(req), 1);
    tick();                                   // E2
    check("t1_req_after_e2", int'(req), 0);
    check("t1_ack_sent",     int'(ack_sent), 1);
    check("t1_cnt_final",    int'(pending_cnt), 0);
    repeat (4) tick();
    check("t1_req_idle",     int'(req), 0);
    check("t1_ack_once",     int'(ack_sent), 0);

    // ---------------- overflow then drained with spaced grants ----------------
    arb_mode   = ARB_OFF;
    done_pulse = 1'b1;
    repeat (4) tick();
    done_pulse = 1'b0;
    check("t2_cnt_full",  int'(pending_cnt), 3);
    check("t2_overflow",  int'(overflow), 1);
    repeat (3) tick();
    check("t2_req_held",  int'(req), 1);
    exp_q.push_back(2'd2);
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd0);
    arb_mode = ARB_AUTO;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (ack_sent) ack_times.push_back(i);
    end
    check("t2_grant_count", ack_times.size(), 3);
    if (ack_times.size() == 3) begin
      check("t2_spacing_1", ack_times[1] - ack_times[0], 3);
      check("t2_spacing_2", ack_times[2] - ack_times[1], 3);
    end
    check("t2_req_idle", int'(req), 0);
    check("t2_cnt_zero", int'(pending_cnt), 0);

    // ---------------- done coincident with grant at full count ----------------
    do_reset();
    done_pulse = 1'b1;
    repeat (3) tick();
    check("t3_cnt_full", int'(pending_cnt), 3);
    check("t3_req",      int'(req), 1);
    exp_q.push_back(2'd3);
    arb_mode = ARB_AUTO;                      // done_pulse still high
    tick();
    arb_mode   = ARB_OFF;
    done_pulse = 1'b0;
    check("t3_cnt_held",    int'(pending_cnt), 3);
    check("t3_no_overflow", int'(overflow), 0);

    // ---------------- wrong winner ID with grant lines up ----------------
    repeat (4) tick();
    check("t4_req_before", int'(req), 1);
    arb_mode = ARB_BAD;
    tick();
    arb_mode = ARB_OFF;
    check("t4_cnt_kept",  int'(pending_cnt), 3);
    check("t4_proto_err", int'(proto_err), 1);
    check("t4_no_ack",    int'(ack_sent), 0);

    // ---------------- contended by MEM, starvation, async reset ----------------
    do_reset();
    arb_mode   = ARB_MEM;
    done_pulse = 1'b1;
    tick();                                   // E0
    tick();                                   // E1
    done_pulse = 1'b0;
    check("t5_req",  int'(req), 1);
    check("t5_cnt2", int'(pending_cnt), 2);
    repeat (7) tick();                        // E8
    check("t5_starved_early", int'(starved), 0);
    tick();                                   // E9
    check("t5_starved",      int'(starved), EXP_STARVED);
    check("t5_req_held",     int'(req), 1);
    check("t5_no_proto_err", int'(proto_err), 0);
    #2;
    rst = 1'b1;
    #1;
    check("t6_req_async", int'(req), 0);
    check("t6_cnt_async", int'(pending_cnt), 0);
    check("t6_starved",   int'(starved), 0);
    check("t6_overflow",  int'(overflow), 0);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    arb_mode = ARB_OFF;
    repeat (4) tick();
    check("t6_req_idle", int'(req), 0);
    check("t6_cnt_idle", int'(pending_cnt), 0);

    repeat (2) tick();
    check("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ack_bus_client.md
# ack_bus_client

Module-side requester for the shared ACK bus. Each source (MEM, SHA, AES, CTRL) instantiates one. It queues that source's completion events, raises `req` toward the ACK bus arbitration logic until the arbiter grants it, retires one pending ACK per grant, then backs off for a programmable gap so lower-priority sources can win. It is the transmit end of the request/grant exchange that the ACK bus top resolves.

## Interface
Parameters:
- `SOURCE_ID`, 2'b00, this source's fixed ACK bus ID (MEM=00, SHA=01, AES=10, CTRL=11).
- `PEND_W`, 2, pending-ACK counter width; maximum queued ACKs is 2^PEND_W−1.
- `GAP_CYCLES`, 1, cycles `req` is held low after each grant; legal range 1..15.
- `TIMEOUT`, 64, REQ-state cycles before starvation is flagged (only with macro).

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `done_pulse`  in  1  one-cycle pulse: the source finished a transaction owing an ACK.
- `ack_ready`  in  1  one-hot grant line from the arbiter for this source.
- `ack_event`  in  1  arbiter broadcast: a grant is issued this cycle.
- `winner_source_id`  in  2  arbiter broadcast winner ID.
- `req`  out  1  request to the ACK bus.
- `ack_sent`  out  1  one-cycle pulse: one pending ACK retired.
- `pending_cnt`  out  PEND_W  queued ACKs not yet granted.
- `overflow`  out  1  sticky: a `done_pulse` was dropped at full count.
- `proto_err`  out  1  sticky: grant inconsistency seen.
- `starved`  out  1  sticky: timeout reached (tied 0 without macro).

## Operation
- Grant: `grant = req & ack_ready & ack_event & (winner_source_id == SOURCE_ID)`.
- Counter: +1 on `done_pulse`, −1 on `grant`. Both in one cycle: unchanged. `done_pulse` at max with no grant: count holds and `overflow` is set. At max with grant: net zero and no overflow.
- FSM states are IDLE, REQ and GAP. `req = (state == REQ)`.
  - IDLE→REQ when `pending_cnt != 0`.
  - REQ→GAP on `grant`; the gap counter loads GAP_CYCLES−1.
  - GAP counts down. At 0 it goes to REQ if the post-update count is nonzero, else to IDLE.
- `proto_err` is set in any cycle where:
  - `ack_ready` is high while `req` is low; or
  - `ack_ready` and `ack_event` are high but `winner_source_id != SOURCE_ID`; or
  - `ack_ready` is high without `ack_event`.
  - A flagged cycle is not a grant.
- Sticky flags clear only on `rst`.

## Timing
- Reset values: `req`=0, `ack_sent`=0, `pending_cnt`=0, `overflow`=0, `proto_err`=0, `starved`=0, state=IDLE.
- `done_pulse` sampled at edge E0 gives count=1 after E0, state=REQ after E1, and `req` high in the cycle after E1.
- Uncontended (the arbiter is combinational): `grant` occurs in the first REQ cycle. At the following edge the count decrements, state becomes GAP, `req` drops, and `ack_sent` is high for exactly that next cycle.
- Minimum spacing between consecutive grants of one source is GAP_CYCLES+1 cycles. `req` is low for exactly GAP_CYCLES cycles.
- `req` stays high, without dropping, for as long as it is ungranted.
- Asynchronous `rst` mid-REQ drops `req` immediately and discards all pending ACKs.

## Configuration
- `ACK_CLIENT_TIMEOUT_EN` defined:
  - A wait counter clears on REQ entry and increments each ungranted REQ cycle.
  - Reaching TIMEOUT sets sticky `starved`.
  - The request is not aborted; the counter saturates.
- Undefined: no wait counter, and `starved` is constant 0.

## Structure
- Shared package `ack_bus_pkg` holds:
  - the ID constants `ID_MEM`, `ID_SHA`, `ID_AES`, `ID_CTRL`;
  - the FSM state encoding (IDLE/REQ/GAP);
  - the GAP counter width (4).
- One sub-module, `ack_client_pending_ctr`: a saturating up/down counter with overflow flag, parameterised by PEND_W.

## Test plan
- SOURCE_ID=01, one `done_pulse`, arbiter model grants immediately: `req` rises 2 cycles later and is high 1 cycle; `ack_sent` pulses once; count returns to 0.
- PEND_W=2, 4 back-to-back `done_pulse`, no grants: count=3 and `overflow`=1. Grant every REQ cycle with GAP_CYCLES=2: 3 grants spaced 3 cycles apart, then IDLE.
- `done_pulse` coincident with grant at count=3: count stays 3 and `overflow` stays 0.
- Grant lines asserted with `winner_source_id`=10 for SOURCE_ID=01: no decrement and `proto_err`=1.
- Contended: MEM requesting continuously blocks SHA. With `ACK_CLIENT_TIMEOUT_EN` and TIMEOUT=8, `starved` sets after 8 REQ cycles and `req` stays high.
- Assert `rst` during REQ with count=2: `req`, `pending_cnt` and flags are 0 immediately; after release the block stays IDLE.
